settings_write_scheduler: RTL and testbench

Schedules all writes into the synth settings register bank (the 16-bit command-word block with a 4-bit address nibble in bits 15:12 and fields below). Two requesters share the bank's single write bus: the SPI host link, which pushes words without flow control, and the on-chip preset loader, which uses a req/ack handshake. The block buffers SPI words in a small FIFO, arbitrates round-robin, and enforces a minimum spacing between writes. It drives a harmless idle word whenever no write is due, because the bank decodes its input on every cycle.

---
 rtl/settings_write_scheduler.sv | 143 ++++++++++++++
 tb/tb_settings_write_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/settings_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : settings_write_scheduler
//  Brief    : Arbitrates SPI (buffered, no flow control) and preset-loader
//             (req/ack) writes onto the single settings-bank write bus, with
//             round-robin fairness and a minimum spacing between writes.
//             Drives IDLE_WORD whenever no write is issued.
//  Revision : 1.0 - initial release
// ============================================================================
module settings_write_scheduler #(
   parameter int          FIFO_DEPTH = 4,
   parameter int          GAP        = 2,
   parameter logic [15:0] IDLE_WORD  = 16'hF000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   spiWord,
   input  logic                          spiValid,
   output logic                          spiOverflow,
   input  logic [15:0]                   presetWord,
   input  logic                          presetReq,
   output logic                          presetAck,
   output logic [15:0]                   dataOut,
   output logic                          writeStrobe,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
   output logic                          busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

   // Round-robin pointer encoding: which requester wins a tie next
   localparam logic [0:0] FAV_SPI    = 1'b0;
   localparam logic [0:0] FAV_PRESET = 1'b1;

   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [0:0]    rr_q, rr_d;
   logic [15:0]   data_out_q, data_out_d;
   logic          strobe_q, strobe_d;
   logic          ack_q, ack_d;
   logic          ovf_q, ovf_d;

   logic          ready;
   logic          cand_a;
   logic          cand_b;
   logic          grant_a;
   logic          grant_b;
   logic          push;

   // Arbitration, FIFO bookkeeping and next output word
   always_comb begin
      ready   = (gap_q == '0);
      cand_a  = (count_q != '0);
      // A request still held during its own ack cycle must not issue twice
      cand_b  = presetReq && !ack_q;
      grant_a = ready && cand_a && (!cand_b || (rr_q == FAV_SPI));
      grant_b = ready && cand_b && (!cand_a || (rr_q == FAV_PRESET));

      // A full FIFO still accepts a word when the head leaves on the same edge
      push    = spiValid && ((count_q < DEPTH_C) || grant_a);

      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q + CW'(push) - CW'(grant_a);
      gap_d      = gap_q;
      rr_d       = rr_q;
      data_out_d = IDLE_WORD;
      strobe_d   = 1'b0;
      ack_d      = 1'b0;
      ovf_d      = spiValid && !push;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      if (grant_a) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         data_out_d = mem_q[rd_ptr_q];
         strobe_d   = 1'b1;
         rr_d       = FAV_PRESET;
      end else if (grant_b) begin
         data_out_d = presetWord;
         strobe_d   = 1'b1;
         ack_d      = 1'b1;
         rr_d       = FAV_SPI;
      end

      if (grant_a || grant_b) begin
         gap_d = GAP_LOAD;
      end else if (!ready) begin
         gap_d = gap_q - GW'(1);
      end
   end

   // FIFO storage; stale contents are harmless because reset clears the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= spiWord;
      end
   end

   // Scheduler state and registered bus outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         gap_q      <= '0;
         rr_q       <= FAV_SPI;
         data_out_q <= IDLE_WORD;
         strobe_q   <= 1'b0;
         ack_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         gap_q      <= gap_d;
         rr_q       <= rr_d;
         data_out_q <= data_out_d;
         strobe_q   <= strobe_d;
         ack_q      <= ack_d;
         ovf_q      <= ovf_d;
      end
   end

   assign dataOut     = data_out_q;
   assign writeStrobe = strobe_q;
   assign presetAck   = ack_q;
   assign spiOverflow = ovf_q;
   assign fifoCount   = count_q;
   assign busy        = (count_q != '0) || presetReq || (gap_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_settings_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_settings_write_scheduler
//  Brief    : Directed bench for settings_write_scheduler; three instances
//             (GAP = 1, 2, 4, FIFO_DEPTH = 4) share one stimulus set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_settings_write_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] spiWord = 16'h0000;
   logic        spiValid = 1'b0;
   logic [15:0] presetWord = 16'h0000;
   logic        presetReq = 1'b0;

   logic [15:0] data1, data2, data4;
   logic        strb1, strb2, strb4;
   logic        ack1, ack2, ack4;
   logic        ovf1, ovf2, ovf4;
   logic [2:0]  cnt1, cnt2, cnt4;
   logic        busy1, busy2, busy4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   settings_write_scheduler #(.FIFO_DEPTH(4), .GAP(1), .IDLE_WORD(16'hF000)) dut_g1 (
      .clk(clk), .rst(rst), .spiWord(spiWord), .spiValid(spiValid), .spiOverflow(ovf1),
      .presetWord(presetWord), .presetReq(presetReq), .presetAck(ack1),
      .dataOut(data1), .writeStrobe(strb1), .fifoCount(cnt1), .busy(busy1));

   settings_write_scheduler #(.FIFO_DEPTH(4), .GAP(2), .IDLE_WORD(16'hF000)) dut_g2 (
      .clk(clk), .rst(rst), .spiWord(spiWord), .spiValid(spiValid), .spiOverflow(ovf2),
      .presetWord(presetWord), .presetReq(presetReq), .presetAck(ack2),
      .dataOut(data2), .writeStrobe(strb2), .fifoCount(cnt2), .busy(busy2));

   settings_write_scheduler #(.FIFO_DEPTH(4), .GAP(4), .IDLE_WORD(16'hF000)) dut_g4 (
      .clk(clk), .rst(rst), .spiWord(spiWord), .spiValid(spiValid), .spiOverflow(ovf4),
      .presetWord(presetWord), .presetReq(presetReq), .presetAck(ack4),
      .dataOut(data4), .writeStrobe(strb4), .fifoCount(cnt4), .busy(busy4));

   // One active edge, then settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      spiValid  = 1'b0;
      presetReq = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (data1 !== 16'hF000) begin bad++; $display("FAIL reset_data_g1: got %h expected F000", data1); end
      total++; if (data4 !== 16'hF000) begin bad++; $display("FAIL reset_data_g4: got %h expected F000", data4); end
      total++; if (strb2 !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b expected 0", strb2); end
      total++; if (cnt2 !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", cnt2); end
      total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy2); end
      total++; if (ack2 !== 1'b0 || ovf2 !== 1'b0) begin bad++; $display("FAIL reset_pulses: got ack=%b ovf=%b expected 0 0", ack2, ovf2); end

      // Burst of four words, then asynchronous reset between edges
      spiValid = 1'b1;
      for (int e = 0; e < 4; e++) begin
         spiWord = 16'h0301 + 16'(e);
         tick();
      end
      total++; if (cnt4 !== 3'd3) begin bad++; $display("FAIL burst_queued_g4: got %0d expected 3", cnt4); end
      total++; if (data2 !== 16'h0302 || strb2 !== 1'b1) begin bad++; $display("FAIL burst_issue_g2: got %h/%b expected 0302/1", data2, strb2); end
      #2;
      rst = 1'b1;
      #1;
      spiValid = 1'b0;
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL async_rst_count: got %0d expected 0", cnt4); end
      total++; if (data2 !== 16'hF000 || strb2 !== 1'b0) begin bad++; $display("FAIL async_rst_data: got %h/%b expected F000/0", data2, strb2); end
      total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL async_rst_busy: got %b expected 0", busy4); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_word();
      do_reset();
      spiValid = 1'b1;
      spiWord  = 16'h0A53;
      tick();   // edge 0: word enters the FIFO
      spiValid = 1'b0;
      total++; if (data2 !== 16'hF000 || strb2 !== 1'b0 || cnt2 !== 3'd1) begin bad++; $display("FAIL single_e0: got %h/%b/%0d expected F000/0/1", data2, strb2, cnt2); end
      tick();   // edge 1: issued
      total++; if (data2 !== 16'h0A53 || strb2 !== 1'b1 || cnt2 !== 3'd0) begin bad++; $display("FAIL single_e1: got %h/%b/%0d expected 0A53/1/0", data2, strb2, cnt2); end
      tick();   // edge 2: back to idle
      total++; if (data2 !== 16'hF000 || strb2 !== 1'b0) begin bad++; $display("FAIL single_e2: got %h/%b expected F000/0", data2, strb2); end
      total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL single_busy: got %b expected 0", busy2); end
   endtask

   task automatic test_burst();
      logic [15:0] words [4]  = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
      logic [15:0] exp_d  [9] = '{16'hF000, 16'h0101, 16'hF000, 16'h0202, 16'hF000,
                                  16'h0303, 16'hF000, 16'h0404, 16'hF000};
      logic        exp_s  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0]  exp_c  [9] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};
      do_reset();
      for (int e = 0; e < 9; e++) begin
         spiValid = (e < 4);
         spiWord  = (e < 4) ? words[e] : 16'h0000;
         tick();
         total++;
         if (data2 !== exp_d[e] || strb2 !== exp_s[e] || cnt2 !== exp_c[e]) begin
            bad++;
            $display("FAIL burst_e%0d: got %h/%b/%0d expected %h/%b/%0d",
                     e, data2, strb2, cnt2, exp_d[e], exp_s[e], exp_c[e]);
         end
      end
   endtask

   task automatic test_overflow();
      int ovf_seen = 0;
      logic [15:0] exp_d;
      logic        exp_s;
      do_reset();
      for (int e = 0; e < 24; e++) begin
         spiValid = (e < 7);
         spiWord  = 16'h0A01 + 16'(e);
         tick();
         exp_s = (e >= 1) && (e <= 21) && (((e - 1) % 4) == 0);
         exp_d = exp_s ? (16'h0A01 + 16'((e - 1) / 4)) : 16'hF000;
         if (ovf4 === 1'b1) ovf_seen++;
         total++;
         if (data4 !== exp_d || strb4 !== exp_s) begin
            bad++;
            $display("FAIL ovf_issue_e%0d: got %h/%b expected %h/%b", e, data4, strb4, exp_d, exp_s);
         end
         total++;
         if (ovf4 !== (e == 6)) begin
            bad++;
            $display("FAIL ovf_pulse_e%0d: got %b expected %b", e, ovf4, (e == 6));
         end
         if (e == 5) begin
            total++;
            if (cnt4 !== 3'd4) begin bad++; $display("FAIL ovf_full_pushpop: got %0d expected 4", cnt4); end
         end
      end
      total++; if (ovf_seen != 1) begin bad++; $display("FAIL ovf_pulse_count: got %0d expected 1", ovf_seen); end
      total++; if (cnt4 !== 3'd0) begin bad++; $display("FAIL ovf_drained: got %0d expected 0", cnt4); end
   endtask

   task automatic test_contention();
      logic        sv   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [15:0] sw   [7] = '{16'h0111, 16'h0222, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      logic        pr   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [15:0] pw   [7] = '{16'h1ABC, 16'h1ABC, 16'h1ABC, 16'h1DEF, 16'h1DEF, 16'h1DEF, 16'h1DEF};
      logic [15:0] ed   [7] = '{16'hF000, 16'h0111, 16'h1ABC, 16'h0222, 16'h1DEF, 16'hF000, 16'hF000};
      logic        es   [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic        ea   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      int acks = 0;
      do_reset();
      for (int e = 0; e < 7; e++) begin
         spiValid   = sv[e];
         spiWord    = sw[e];
         presetReq  = pr[e];
         presetWord = pw[e];
         tick();
         if (ack1 === 1'b1) acks++;
         total++;
         if (data1 !== ed[e] || strb1 !== es[e] || ack1 !== ea[e]) begin
            bad++;
            $display("FAIL contend_e%0d: got %h/%b/%b expected %h/%b/%b",
                     e, data1, strb1, ack1, ed[e], es[e], ea[e]);
         end
      end
      total++; if (acks != 2) begin bad++; $display("FAIL contend_ack_count: got %0d expected 2", acks); end
      presetReq = 1'b0;
   endtask

   task automatic test_idle();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         tick();
         total++;
         if (data1 !== 16'hF000 || strb1 !== 1'b0 || busy1 !== 1'b0 ||
             data2 !== 16'hF000 || strb2 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL idle_c%0d: got %h/%b/%b %h/%b/%b expected F000/0/0",
                     c, data1, strb1, busy1, data2, strb2, busy2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_burst();
      test_overflow();
      test_contention();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
